ctrl_decode_pipe: RTL and testbench

Parametrised successor to the single-cycle main decoder. It decodes the full RV32I base opcode set (adds jal, jalr, lui and auipc) into a wider control word. It registers that word through the E, M and W pipeline stages, with stall, flush and illegal-opcode tracking. It sits between the Decode stage datapath and the hazard unit, and replaces the scattered ID/EX, EX/MEM and MEM/WB control registers.

---
 rtl/ctrl_pkg.sv | 83 ++++++++
 rtl/ctrl_decode.sv | 89 ++++++++
 rtl/ctrl_decode_pipe.sv | 86 ++++++++
 tb/tb_ctrl_decode_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-path types: RV32I opcodes, control-field encodings and the
// per-stage control words carried down the E/M/W pipeline.
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCA_RS1  = 2'b00,
    SRCA_PC   = 2'b01,
    SRCA_ZERO = 2'b10
  } src_a_sel_t;

  typedef struct packed {
    logic        reg_write;
    imm_src_t    imm_src;
    logic        alu_src;
    logic        mem_write;
    result_src_t result_src;
    logic        branch;
    alu_op_t     alu_op;
    logic        jump;
    logic        jump_reg;
    src_a_sel_t  src_a_sel;
    logic        illegal;
  } ctrl_word_t;

  localparam ctrl_word_t BUBBLE = '0;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    result_src_t result_src;
  } ctrl_m_t;

  typedef struct packed {
    logic        reg_write;
    result_src_t result_src;
  } ctrl_w_t;

  function automatic ctrl_m_t to_m(input ctrl_word_t w);
    ctrl_m_t m;
    m.reg_write  = w.reg_write;
    m.mem_write  = w.mem_write;
    m.result_src = w.result_src;
    return m;
  endfunction

  function automatic ctrl_w_t to_w(input ctrl_m_t m);
    ctrl_w_t w;
    w.reg_write  = m.reg_write;
    w.result_src = m.result_src;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I main decoder: opcode to full control word, with the
// upper/jump opcodes optionally disabled for the legacy subset.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EN_UPPER = 1'b1
) (
  input  logic [6:0] op,
  input  logic       valid,
  output ctrl_word_t word
);

  always_comb begin
    // NOTE: the whole word gets a default before the case, so every field is
    // driven on every path and no latch can be inferred.
    word = BUBBLE;
    if (valid) begin
      case (op)
        OP_LOAD: begin
          word.reg_write  = 1'b1;
          word.alu_src    = 1'b1;
          word.result_src = RES_MEM;
        end
        OP_STORE: begin
          word.imm_src   = IMM_S;
          word.alu_src   = 1'b1;
          word.mem_write = 1'b1;
        end
        OP_R: begin
          word.reg_write = 1'b1;
          word.alu_op    = ALU_FUNCT;
        end
        OP_IALU: begin
          word.reg_write = 1'b1;
          word.alu_src   = 1'b1;
          word.alu_op    = ALU_FUNCT;
        end
        OP_BRANCH: begin
          word.imm_src = IMM_B;
          word.branch  = 1'b1;
          word.alu_op  = ALU_SUB;
        end
        OP_JAL: begin
          if (EN_UPPER) begin
            word.reg_write  = 1'b1;
            word.imm_src    = IMM_J;
            word.result_src = RES_PC4;
            word.jump       = 1'b1;
          end else begin
            word.illegal = 1'b1;
          end
        end
        OP_JALR: begin
          if (EN_UPPER) begin
            word.reg_write  = 1'b1;
            word.alu_src    = 1'b1;
            word.result_src = RES_PC4;
            word.jump       = 1'b1;
            word.jump_reg   = 1'b1;
          end else begin
            word.illegal = 1'b1;
          end
        end
        OP_LUI: begin
          if (EN_UPPER) begin
            word.reg_write = 1'b1;
            word.imm_src   = IMM_U;
            word.alu_src   = 1'b1;
            word.src_a_sel = SRCA_ZERO;
          end else begin
            word.illegal = 1'b1;
          end
        end
        OP_AUIPC: begin
          if (EN_UPPER) begin
            word.reg_write = 1'b1;
            word.imm_src   = IMM_U;
            word.alu_src   = 1'b1;
            word.src_a_sel = SRCA_PC;
          end else begin
            word.illegal = 1'b1;
          end
        end
        default: word.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Decode-stage control generation plus the E/M/W control registers and a
// saturating count of illegal opcodes that left the E stage.
module ctrl_decode_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned ILLEGAL_CNT_W = 8,
  parameter bit          EN_UPPER      = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               op_d,
  input  logic                     valid_d,
  input  logic                     stall_e,
  input  logic                     flush_e,
  output logic                     reg_write_e,
  output logic                     mem_write_e,
  output logic                     branch_e,
  output logic                     jump_e,
  output logic                     jump_reg_e,
  output logic                     alu_src_e,
  output logic [2:0]               imm_src_e,
  output logic [1:0]               result_src_e,
  output logic [1:0]               alu_op_e,
  output logic [1:0]               src_a_sel_e,
  output logic                     illegal_e,
  output logic                     reg_write_m,
  output logic                     mem_write_m,
  output logic [1:0]               result_src_m,
  output logic                     reg_write_w,
  output logic [1:0]               result_src_w,
  output logic [ILLEGAL_CNT_W-1:0] illegal_cnt
);

  ctrl_word_t               ctrl_d;
  ctrl_word_t               ctrl_e;
  ctrl_m_t                  ctrl_m;
  ctrl_w_t                  ctrl_w;
  logic [ILLEGAL_CNT_W-1:0] cnt_q;
  logic                     e_advance;

  ctrl_decode #(.EN_UPPER(EN_UPPER)) u_decode (
    .op    (op_d),
    .valid (valid_d),
    .word  (ctrl_d)
  );

  // A flush retires E just like a normal advance, so it also counts.
  assign e_advance = flush_e || !stall_e;

  // NOTE: non-blocking assignments let M and W capture the pre-edge E/M
  // values, which is what makes this a shift register and not a wire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_e <= BUBBLE;
      ctrl_m <= '0;
      ctrl_w <= '0;
      cnt_q  <= '0;
    end else begin
      if (flush_e)       ctrl_e <= BUBBLE;
      else if (!stall_e) ctrl_e <= ctrl_d;
      ctrl_m <= to_m(ctrl_e);
      ctrl_w <= to_w(ctrl_m);
      if (ctrl_e.illegal && e_advance && (cnt_q != '1))
        cnt_q <= cnt_q + ILLEGAL_CNT_W'(1);
    end
  end

  assign reg_write_e  = ctrl_e.reg_write;
  assign mem_write_e  = ctrl_e.mem_write;
  assign branch_e     = ctrl_e.branch;
  assign jump_e       = ctrl_e.jump;
  assign jump_reg_e   = ctrl_e.jump_reg;
  assign alu_src_e    = ctrl_e.alu_src;
  assign imm_src_e    = ctrl_e.imm_src;
  assign result_src_e = ctrl_e.result_src;
  assign alu_op_e     = ctrl_e.alu_op;
  assign src_a_sel_e  = ctrl_e.src_a_sel;
  assign illegal_e    = ctrl_e.illegal;
  assign reg_write_m  = ctrl_m.reg_write;
  assign mem_write_m  = ctrl_m.mem_write;
  assign result_src_m = ctrl_m.result_src;
  assign reg_write_w  = ctrl_w.reg_write;
  assign result_src_w = ctrl_w.result_src;
  assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe: three instances (default, 2-bit counter,
// legacy subset) share one stimulus stream; expectations are hand-written.
module tb_ctrl_decode_pipe;

  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] RT    = 7'b0110011;
  localparam logic [6:0] IALU  = 7'b0010011;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] BAD   = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op_d;
  logic       valid_d, stall_e, flush_e;

  logic       reg_write_e [3], mem_write_e [3], branch_e [3], jump_e [3];
  logic       jump_reg_e [3], alu_src_e [3], illegal_e [3];
  logic [2:0] imm_src_e [3];
  logic [1:0] result_src_e [3], alu_op_e [3], src_a_sel_e [3];
  logic       reg_write_m [3], mem_write_m [3], reg_write_w [3];
  logic [1:0] result_src_m [3], result_src_w [3];
  logic [7:0] cnt [3];
  logic [15:0] obs [3];
  logic [22:0] all_out [3];

  always #5 clk = ~clk;

  // Instance 0: defaults; 1: 2-bit counter; 2: legacy subset (EN_UPPER=0).
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned CW = (g == 1) ? 2 : 8;
    logic [CW-1:0] cnt_raw;
    ctrl_decode_pipe #(.ILLEGAL_CNT_W(CW), .EN_UPPER((g == 2) ? 1'b0 : 1'b1)) dut (
      .clk          (clk),
      .reset        (reset),
      .op_d         (op_d),
      .valid_d      (valid_d),
      .stall_e      (stall_e),
      .flush_e      (flush_e),
      .reg_write_e  (reg_write_e[g]),
      .mem_write_e  (mem_write_e[g]),
      .branch_e     (branch_e[g]),
      .jump_e       (jump_e[g]),
      .jump_reg_e   (jump_reg_e[g]),
      .alu_src_e    (alu_src_e[g]),
      .imm_src_e    (imm_src_e[g]),
      .result_src_e (result_src_e[g]),
      .alu_op_e     (alu_op_e[g]),
      .src_a_sel_e  (src_a_sel_e[g]),
      .illegal_e    (illegal_e[g]),
      .reg_write_m  (reg_write_m[g]),
      .mem_write_m  (mem_write_m[g]),
      .result_src_m (result_src_m[g]),
      .reg_write_w  (reg_write_w[g]),
      .result_src_w (result_src_w[g]),
      .illegal_cnt  (cnt_raw)
    );
    assign cnt[g] = 8'(cnt_raw);
    assign obs[g] = {reg_write_e[g], imm_src_e[g], alu_src_e[g], mem_write_e[g],
                     result_src_e[g], branch_e[g], alu_op_e[g], jump_e[g],
                     jump_reg_e[g], src_a_sel_e[g], illegal_e[g]};
    assign all_out[g] = {obs[g], reg_write_m[g], mem_write_m[g], result_src_m[g],
                         reg_write_w[g], result_src_w[g]};
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Field order: RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch,
  // ALUOp, Jump, JumpReg, SrcASel, illegal.
  function automatic logic [15:0] mk(input logic rw, input logic [2:0] imm,
                                     input logic as, input logic mw,
                                     input logic [1:0] rs, input logic br,
                                     input logic [1:0] ao, input logic j,
                                     input logic jr, input logic [1:0] sa,
                                     input logic ill);
    return {rw, imm, as, mw, rs, br, ao, j, jr, sa, ill};
  endfunction

  function automatic logic is_upper(input logic [6:0] op);
    return (op == JAL) || (op == JALR) || (op == LUI) || (op == AUIPC);
  endfunction

  task automatic cyc(input logic [6:0] op, input logic v, input logic st, input logic fl);
    op_d    = op;
    valid_d = v;
    stall_e = st;
    flush_e = fl;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic        valid;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [12];
  logic [15:0] exp_lw;

  initial begin
    exp_lw  = mk(1, 3'b000, 1, 0, 2'b01, 0, 2'b00, 0, 0, 2'b00, 0);
    tbl[0]  = '{"lw",     LW,     1'b1, exp_lw};
    tbl[1]  = '{"sw",     SW,     1'b1, mk(0, 3'b001, 1, 1, 2'b00, 0, 2'b00, 0, 0, 2'b00, 0)};
    tbl[2]  = '{"rtype",  RT,     1'b1, mk(1, 3'b000, 0, 0, 2'b00, 0, 2'b10, 0, 0, 2'b00, 0)};
    tbl[3]  = '{"ialu",   IALU,   1'b1, mk(1, 3'b000, 1, 0, 2'b00, 0, 2'b10, 0, 0, 2'b00, 0)};
    tbl[4]  = '{"branch", BR,     1'b1, mk(0, 3'b010, 0, 0, 2'b00, 1, 2'b01, 0, 0, 2'b00, 0)};
    tbl[5]  = '{"jal",    JAL,    1'b1, mk(1, 3'b011, 0, 0, 2'b10, 0, 2'b00, 1, 0, 2'b00, 0)};
    tbl[6]  = '{"jalr",   JALR,   1'b1, mk(1, 3'b000, 1, 0, 2'b10, 0, 2'b00, 1, 1, 2'b00, 0)};
    tbl[7]  = '{"lui",    LUI,    1'b1, mk(1, 3'b100, 1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b10, 0)};
    tbl[8]  = '{"auipc",  AUIPC,  1'b1, mk(1, 3'b100, 1, 0, 2'b00, 0, 2'b00, 0, 0, 2'b01, 0)};
    tbl[9]  = '{"bad7f",  BAD,    1'b1, 16'h0001};
    tbl[10] = '{"bad00",  7'h00,  1'b1, 16'h0001};
    tbl[11] = '{"bubble", LW,     1'b0, 16'h0000};

    reset = 1'b1; op_d = '0; valid_d = 1'b0; stall_e = 1'b0; flush_e = 1'b0;
    #3;
    check("reset_out", 32'(all_out[0]), 32'h0);
    check("reset_cnt", 32'(cnt[0]), 32'h0);
    #4 reset = 1'b0;

    // Opcode sweep: each vector appears on E one edge after being applied.
    foreach (tbl[i]) begin
      cyc(tbl[i].op, tbl[i].valid, 1'b0, 1'b0);
      check({"dec_", tbl[i].name}, 32'(obs[0]), 32'(tbl[i].exp));
      check({"legacy_", tbl[i].name}, 32'(obs[2]),
            32'((tbl[i].valid && is_upper(tbl[i].op)) ? 16'h0001 : tbl[i].exp));
    end
    check("sweep_cnt_default", 32'(cnt[0]), 32'd2);
    check("sweep_cnt_narrow",  32'(cnt[1]), 32'd2);
    check("sweep_cnt_legacy",  32'(cnt[2]), 32'd6);

    // Pipeline shift: lw, sw, R.
    cyc(LW, 1'b1, 1'b0, 1'b0);
    cyc(SW, 1'b1, 1'b0, 1'b0);
    cyc(RT, 1'b1, 1'b0, 1'b0);
    check("shift_reg_write_w",  32'(reg_write_w[0]), 32'd1);
    check("shift_result_src_w", 32'(result_src_w[0]), 32'd1);
    check("shift_mem_write_m",  32'(mem_write_m[0]), 32'd1);
    check("shift_reg_write_m",  32'(reg_write_m[0]), 32'd0);

    // Stall holds E while M and W keep advancing; flush beats stall.
    cyc(LW, 1'b1, 1'b0, 1'b0);
    cyc(RT, 1'b1, 1'b1, 1'b0);
    check("stall1_e",            32'(obs[0]), 32'(exp_lw));
    check("stall1_result_src_m", 32'(result_src_m[0]), 32'd1);
    check("stall1_reg_write_m",  32'(reg_write_m[0]), 32'd1);
    cyc(RT, 1'b1, 1'b1, 1'b0);
    check("stall2_e",            32'(obs[0]), 32'(exp_lw));
    check("stall2_result_src_w", 32'(result_src_w[0]), 32'd1);
    check("stall2_reg_write_w",  32'(reg_write_w[0]), 32'd1);
    cyc(RT, 1'b1, 1'b1, 1'b1);
    check("flush_over_stall_e",  32'(obs[0]), 32'h0);
    check("flush_result_src_m",  32'(result_src_m[0]), 32'd1);

    // Asynchronous reset in the middle of lw/sw traffic.
    cyc(LW, 1'b1, 1'b0, 1'b0);
    cyc(SW, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("async_reset_out%0d", g), 32'(all_out[g]), 32'h0);
      check($sformatf("async_reset_cnt%0d", g), 32'(cnt[g]), 32'h0);
    end
    #3 reset = 1'b0;

    // Stalled illegal instruction is counted once, when E advances.
    cyc(BAD, 1'b1, 1'b0, 1'b0);
    check("ill_load_e",   32'(illegal_e[0]), 32'd1);
    check("ill_load_cnt", 32'(cnt[0]), 32'd0);
    cyc(BAD, 1'b1, 1'b1, 1'b0);
    cyc(BAD, 1'b1, 1'b1, 1'b0);
    check("ill_stalled_e",   32'(illegal_e[0]), 32'd1);
    check("ill_stalled_cnt", 32'(cnt[0]), 32'd0);
    cyc(LW, 1'b1, 1'b0, 1'b0);
    check("ill_release_cnt", 32'(cnt[0]), 32'd1);
    check("ill_release_e",   32'(obs[0]), 32'(exp_lw));
    cyc(BAD, 1'b1, 1'b0, 1'b0);
    cyc(LW, 1'b1, 1'b1, 1'b1);
    check("ill_flush_cnt", 32'(cnt[0]), 32'd2);
    check("ill_flush_e",   32'(obs[0]), 32'h0);

    // Saturation: five illegal ops on the 2-bit counter stop at 3.
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    for (int k = 0; k < 4; k++) cyc(BAD, 1'b1, 1'b0, 1'b0);
    check("sat_reach_narrow", 32'(cnt[1]), 32'd3);
    cyc(BAD, 1'b1, 1'b0, 1'b0);
    cyc(LW, 1'b0, 1'b0, 1'b0);
    check("sat_hold_narrow", 32'(cnt[1]), 32'd3);
    check("sat_default",     32'(cnt[0]), 32'd5);
    check("sat_legacy_e",    32'(obs[2]), 32'h0);

    // Legacy: jal decodes as illegal with every control low.
    cyc(JAL, 1'b1, 1'b0, 1'b0);
    check("legacy_jal_e",   32'(obs[2]), 32'h0001);
    check("legacy_jal_def", 32'(obs[0]), 32'(tbl[5].exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
